// File: rtl/tds_pad_frame_emulator.sv
// Transmit-side emulator for the four TDS pad-data links: one {bcid, payload}
// frame per bunch crossing, with an independent BC-granular skew per link.
module tds_pad_frame_emulator #(
    parameter int VALID_PERIOD = 4,
    parameter int BCID_MAX     = 3563,
    parameter int MAX_SKEW     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         bcid_load,
    input  logic [11:0]  bcid_preset,
    input  logic [1:0]   pattern_mode,
    input  logic [103:0] user_payload,
    input  logic [2:0]   link_skew_0,
    input  logic [2:0]   link_skew_1,
    input  logic [2:0]   link_skew_2,
    input  logic [2:0]   link_skew_3,
    output logic [115:0] pad_data_0,
    output logic [115:0] pad_data_1,
    output logic [115:0] pad_data_2,
    output logic [115:0] pad_data_3,
    output logic         pad_data_valid_0,
    output logic         pad_data_valid_1,
    output logic         pad_data_valid_2,
    output logic         pad_data_valid_3,
    output logic [11:0]  bcid_out,
    output logic [31:0]  frame_count
);

    localparam int DW = (VALID_PERIOD > 2) ? $clog2(VALID_PERIOD) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(VALID_PERIOD - 1);
    localparam logic [11:0]   BCID_LAST = 12'(BCID_MAX);

    logic [DW-1:0]  divider;
    logic           strobe;
    logic [11:0]    bcid_reg;
    logic [31:0]    frame_cnt;
    logic [103:0]   payload;
    logic [115:0]   ref_frame;
    logic [115:0]   stage [MAX_SKEW];
    logic [115:0]   pad_q [4];
    logic [115:0]   pad_next [4];
    logic [2:0]     skew_raw [4];
    int             skew_c [4];
    logic           valid_q;
    logic [11:0]    bcid_q;

    assign skew_raw[0] = link_skew_0;
    assign skew_raw[1] = link_skew_1;
    assign skew_raw[2] = link_skew_2;
    assign skew_raw[3] = link_skew_3;

    assign strobe    = enable && (divider == DIV_LAST);
    assign ref_frame = {bcid_reg, payload};

    always_comb begin
        payload = '0;
        case (pattern_mode)
            2'd1:    payload = {8'hA5, frame_cnt, frame_cnt, frame_cnt};
            2'd2:    payload = user_payload;
            default: payload = '0;
        endcase
    end

    // Link k taps the pre-shift delay line, so a frame built now reaches it
    // skew_k strobes later; stages still at reset value give the zero fill.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            skew_c[k] = int'(skew_raw[k]);
            if (skew_c[k] > MAX_SKEW) skew_c[k] = MAX_SKEW;
            pad_next[k] = ref_frame;
            for (int j = 0; j < MAX_SKEW; j++) begin
                if (skew_c[k] == j + 1) pad_next[k] = stage[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divider   <= '0;
            bcid_reg  <= '0;
            frame_cnt <= '0;
            valid_q   <= 1'b0;
            bcid_q    <= '0;
            for (int j = 0; j < MAX_SKEW; j++) stage[j] <= '0;
            for (int k = 0; k < 4; k++) pad_q[k] <= '0;
        end else begin
            if (enable) divider <= (divider == DIV_LAST) ? '0 : divider + 1'b1;
            valid_q <= strobe;
            if (strobe) begin
                stage[0] <= ref_frame;
                for (int j = 1; j < MAX_SKEW; j++) stage[j] <= stage[j-1];
                for (int k = 0; k < 4; k++) pad_q[k] <= pad_next[k];
                bcid_q    <= bcid_reg;
                frame_cnt <= frame_cnt + 32'd1;
            end
            // A load coincident with a strobe wins; the frame above still
            // used the old BCID.
            if (bcid_load)
                bcid_reg <= bcid_preset;
            else if (strobe)
                bcid_reg <= (bcid_reg == BCID_LAST) ? 12'd0 : bcid_reg + 12'd1;
        end
    end

    assign pad_data_0       = pad_q[0];
    assign pad_data_1       = pad_q[1];
    assign pad_data_2       = pad_q[2];
    assign pad_data_3       = pad_q[3];
    assign pad_data_valid_0 = valid_q;
    assign pad_data_valid_1 = valid_q;
    assign pad_data_valid_2 = valid_q;
    assign pad_data_valid_3 = valid_q;
    assign bcid_out         = bcid_q;
    assign frame_count      = frame_cnt;

endmodule

// File: doc/tds_pad_frame_emulator.md
Name: tds_pad_frame_emulator

Overview:
- Transmit-side emulator for the four TDS pad-data links. Generates 116-bit pad frames with the BCID in bits [115:104] and the payload in [103:0], one frame per bunch crossing.
- Each link can be given an independent programmable latency skew, in BC units, so the four streams arrive mutually misaligned.
- Drives the downstream link-latency alignment logic directly on the bench and in loopback firmware. Used to validate BCID-based realignment without detector hardware.

Parameters:
- VALID_PERIOD, 4, clk cycles per bunch crossing (160 MHz clk / 40 MHz BC); legal 2..16.
- BCID_MAX, 3563, last BCID value before wrap to 0.
- MAX_SKEW, 4, maximum per-link skew in BCs; sets delay-line depth.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- enable  in  1  1 = generate frames; 0 = pause.
- bcid_load  in  1  one-cycle pulse; preset the BCID counter.
- bcid_preset  in  12  value loaded on bcid_load.
- pattern_mode  in  2  payload select: 0 zero, 1 counter, 2 user, 3 zero.
- user_payload  in  104  payload used when pattern_mode=2.
- link_skew_0..link_skew_3  in  3 each  per-link delay in BCs; values >MAX_SKEW clamp to MAX_SKEW.
- pad_data_0..pad_data_3  out  116 each  per-link frame, {bcid[11:0], payload[103:0]}.
- pad_data_valid_0..pad_data_valid_3  out  1 each  one-cycle frame strobe.
- bcid_out  out  12  BCID of the frame most recently emitted on skew-0 timing.
- frame_count  out  32  number of frames generated since reset.

Behaviour:
- Reset (rst_n=0 at a rising edge) clears:
  - divider to 0, bcid register to 0, frame_count to 0;
  - all delay-line stages to 116'h0;
  - all pad_data outputs to 0, all valids to 0, bcid_out to 0.
- Reset mid-operation discards in-flight frames. The first frame after reset carries BCID 0.
- Divider counts 0..VALID_PERIOD-1 while enable=1.
  - strobe = enable & (divider == VALID_PERIOD-1).
  - enable=0: divider holds its value, no strobes, valids stay 0, data outputs hold.
- Reference frame = {bcid_reg, payload}.
  - Counter payload = {8'hA5, frame_count, frame_count, frame_count}.
- On each strobe edge:
  - delay stage[0] <= reference frame; stage[k] <= stage[k-1] for k=1..MAX_SKEW-1.
  - pad_data_k <= reference frame when skew_k=0, else the pre-shift stage[skew_k-1].
  - All four pad_data_valid_k <= 1 for exactly one cycle; all four links strobe in the same cycle.
  - bcid_out <= bcid_reg.
  - bcid_reg <= (bcid_reg == BCID_MAX) ? 0 : bcid_reg+1.
  - frame_count <= frame_count+1; wraps modulo 2^32.
- Latency: a frame built at strobe edge N appears on link k at strobe edge N+skew_k.
  - At a given valid, link k therefore carries BCID B-skew_k (modulo BCID_MAX+1), where B is the skew-0 BCID.
- Fill: until skew_k strobes have occurred, link k outputs 116'h0 with valid still asserted. This is deliberate; it exercises the aligner's no-match fallback.
- bcid_load:
  - Without a strobe: bcid_reg <= bcid_preset.
  - Simultaneous with a strobe: the load wins. bcid_reg <= bcid_preset; the frame emitted at that edge uses the old bcid_reg; the next frame carries the preset.
  - A preset above BCID_MAX is loaded as-is. The counter wraps to 0 on the next increment only when bcid_reg==BCID_MAX; otherwise it counts to 4095 then 0 (natural 12-bit wrap).
- Skew or pattern_mode changes take effect at the next strobe. No flush, no glitch on outputs between strobes.
- Non-strobe cycles: valids 0, all data registers hold.

Test Plan:
- Reset, enable=1, all skews 0, pattern 0: valid every 4th cycle starting cycle 4; all links show BCID 0,1,2…; payload 0; frame_count increments by 1 per valid.
- Skews 0/1/2/4, after 10 frames: at the 11th valid, links 0..3 carry BCID 10/9/8/6. Before fill, link 3 shows 116'h0 on valids 1–4.
- bcid_load, preset=3562: frames 3562, 3563, 0, 1 (wrap at BCID_MAX). bcid_out tracks the skew-0 link.
- bcid_load in the same cycle as a strobe, preset=100: that frame keeps the old BCID; the next frame is 100.
- pattern_mode=1, then 2 with user_payload=104'hDEAD…: payload changes exactly at the next strobe. Counter payload's upper byte is 8'hA5 and its low 32 bits equal the frame_count.
- Toggle enable low for 7 cycles, then reassert rst_n=0 mid-run: no valids during pause and BCID resumes contiguously; after reset all outputs 0 and the next BCID is 0. link_skew=7 behaves as skew 4.
